lcd_cmd_receiver: RTL and testbench

//  Consumer end of the toggle-signalled LCD command channel: detects each LCD_CMD_SIG transition,

---
 rtl/lcd_cmd_pkg.sv | 38 +++
 rtl/lcd_cmd_fifo.sv | 56 +++++
 rtl/lcd_cmd_receiver.sv | 277 +++++++++++++++++++++++++++
 tb/tb_lcd_cmd_receiver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_cmd_pkg.sv
// Shared definitions for the LCD command receiver: opcodes, command-word
// field positions, pixel type and execute-FSM state encoding.
package lcd_cmd_pkg;

    // Opcodes carried in the top nibble of the command word
    localparam logic [3:0] OP_NOP        = 4'h0;
    localparam logic [3:0] OP_SET_COLOR  = 4'h1;
    localparam logic [3:0] OP_SET_ORIGIN = 4'h2;
    localparam logic [3:0] OP_FILL_RECT  = 4'h3;
    localparam logic [3:0] OP_PIXEL      = 4'h4;

    // Field bit positions inside the 32-bit command word
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 28;
    localparam int X_MSB     = 21;
    localparam int X_LSB     = 11;
    localparam int Y_MSB     = 10;
    localparam int Y_LSB     = 0;
    localparam int COLOR_MSB = 15;
    localparam int COLOR_LSB = 0;

    localparam int COORD_W = 11;

    // RGB565 pixel
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Execute FSM states
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WRITE
    } state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO. Head word is read combinationally so the FSM can
// register it in the same cycle it pops. A push into a full FIFO is accepted
// only when a pop frees a slot on the same edge; otherwise it is dropped.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr_reg[PTR_W-1:0]];

    // Storage array: no reset so it maps onto plain RAM
    always_ff @(posedge HCLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= din;
        end
    end

    // Read/write pointers; reset flushes the queue
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_cmd_receiver.sv
// Consumer end of the toggle-signalled LCD command channel. Synchronizes the
// toggle strobe, captures each command into a FIFO and executes commands as
// framebuffer writes (single pixels and clipped rectangle fills).
module lcd_cmd_receiver
    import lcd_cmd_pkg::*;
#(
    parameter int H_RES       = 800,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            LCD_CMD_SIG,
    input  logic [31:0]                     LCD_CMD,
    output logic                            fb_we,
    output logic [ADDR_W-1:0]               fb_addr,
    output logic [15:0]                     fb_wdata,
    input  logic                            fb_ready,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            err_ovf,
    output logic                            err_op,
    input  logic                            clr_err
);

    localparam logic [COORD_W:0]  H_RES_C = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0]  V_RES_C = (COORD_W+1)'(V_RES);
    localparam logic [ADDR_W-1:0] H_ADDR  = ADDR_W'(H_RES);

    // ------------------------------------------------------------------
    // Toggle capture
    // ------------------------------------------------------------------
    logic sig_sync;
    logic sig_hist_reg;
    logic cmd_push;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sig_sync = LCD_CMD_SIG;
        end else begin : g_sync
            logic sync_reg [SYNC_STAGES];
            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                // One synchronizer flop; stage 0 samples the raw strobe
                always_ff @(posedge HCLK or negedge HRESETn) begin
                    if (!HRESETn) begin
                        sync_reg[gi] <= 1'b0;
                    end else if (gi == 0) begin
                        sync_reg[gi] <= LCD_CMD_SIG;
                    end else begin
                        sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                    end
                end
            end
            assign sig_sync = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // Toggle history: any difference from the synchronized strobe is a new command
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sig_hist_reg <= 1'b0;
        end else begin
            sig_hist_reg <= sig_sync;
        end
    end

    assign cmd_push = sig_sync ^ sig_hist_reg;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [31:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    state_t      state_reg;

    assign fifo_pop = (state_reg == S_IDLE) && !fifo_empty;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .push    (cmd_push),
        .pop     (fifo_pop),
        .din     (LCD_CMD),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Overflow flag: set when a push finds no room; set beats clear
    logic err_ovf_reg;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_ovf_reg <= 1'b0;
        end else if (cmd_push && fifo_full && !fifo_pop) begin
            err_ovf_reg <= 1'b1;
        end else if (clr_err) begin
            err_ovf_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Execute FSM
    // ------------------------------------------------------------------
    logic [31:0]        cmd_reg;
    rgb565_t            color_reg;
    logic [COORD_W-1:0] x0_reg;
    logic [COORD_W-1:0] y0_reg;
    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;
    logic [COORD_W-1:0] x_start_reg;
    logic [COORD_W-1:0] x_last_reg;
    logic [COORD_W-1:0] y_last_reg;
    logic [ADDR_W-1:0]  row_base_reg;
    logic [ADDR_W-1:0]  fb_addr_reg;
    rgb565_t            fb_wdata_reg;
    logic               fb_we_reg;
    logic               err_op_reg;

    logic [3:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [COORD_W:0]   x_room;
    logic [COORD_W:0]   y_room;
    logic [COORD_W:0]   w_eff;
    logic [COORD_W:0]   h_eff;
    logic [COORD_W-1:0] fill_x_last;
    logic [COORD_W-1:0] fill_y_last;
    logic               fill_empty;
    logic               pixel_ok;
    logic [ADDR_W-1:0]  fill_base;
    logic [ADDR_W-1:0]  pixel_base;
    logic [ADDR_W-1:0]  next_row_base;
    logic               unused_cmd_bits;

    assign cmd_op          = cmd_reg[OP_MSB:OP_LSB];
    assign cmd_x           = cmd_reg[X_MSB:X_LSB];
    assign cmd_y           = cmd_reg[Y_MSB:Y_LSB];
    assign unused_cmd_bits = ^cmd_reg[OP_LSB-1:X_MSB+1];

    // Clip the rectangle against the screen and precompute start bases
    always_comb begin
        w_eff       = '0;
        h_eff       = '0;
        x_room      = H_RES_C - {1'b0, x0_reg};
        y_room      = V_RES_C - {1'b0, y0_reg};
        if ({1'b0, x0_reg} < H_RES_C) begin
            w_eff = ({1'b0, cmd_x} < x_room) ? {1'b0, cmd_x} : x_room;
        end
        if ({1'b0, y0_reg} < V_RES_C) begin
            h_eff = ({1'b0, cmd_y} < y_room) ? {1'b0, cmd_y} : y_room;
        end
        fill_empty  = (w_eff == '0) || (h_eff == '0);
        fill_x_last = x0_reg + w_eff[COORD_W-1:0] - 1'b1;
        fill_y_last = y0_reg + h_eff[COORD_W-1:0] - 1'b1;
        pixel_ok    = ({1'b0, cmd_x} < H_RES_C) && ({1'b0, cmd_y} < V_RES_C);
        fill_base   = ADDR_W'(y0_reg) * H_ADDR;
        pixel_base  = ADDR_W'(cmd_y) * H_ADDR;
    end

    assign next_row_base = row_base_reg + H_ADDR;

    // Command sequencing, drawing state and registered framebuffer port
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= S_IDLE;
            cmd_reg      <= '0;
            color_reg    <= '0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            x_start_reg  <= '0;
            x_last_reg   <= '0;
            y_last_reg   <= '0;
            row_base_reg <= '0;
            fb_addr_reg  <= '0;
            fb_wdata_reg <= '0;
            fb_we_reg    <= 1'b0;
            err_op_reg   <= 1'b0;
        end else begin
            if (clr_err) begin
                err_op_reg <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cmd_reg   <= fifo_dout;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_reg <= S_IDLE;
                    case (cmd_op)
                        OP_NOP: begin
                        end
                        OP_SET_COLOR: begin
                            color_reg <= rgb565_t'(cmd_reg[COLOR_MSB:COLOR_LSB]);
                        end
                        OP_SET_ORIGIN: begin
                            x0_reg <= cmd_x;
                            y0_reg <= cmd_y;
                        end
                        OP_FILL_RECT: begin
                            if (!fill_empty) begin
                                x_reg        <= x0_reg;
                                y_reg        <= y0_reg;
                                x_start_reg  <= x0_reg;
                                x_last_reg   <= fill_x_last;
                                y_last_reg   <= fill_y_last;
                                row_base_reg <= fill_base;
                                fb_addr_reg  <= fill_base + ADDR_W'(x0_reg);
                                fb_wdata_reg <= color_reg;
                                fb_we_reg    <= 1'b1;
                                state_reg    <= S_WRITE;
                            end
                        end
                        OP_PIXEL: begin
                            if (pixel_ok) begin
                                x_reg        <= cmd_x;
                                y_reg        <= cmd_y;
                                x_start_reg  <= cmd_x;
                                x_last_reg   <= cmd_x;
                                y_last_reg   <= cmd_y;
                                row_base_reg <= pixel_base;
                                fb_addr_reg  <= pixel_base + ADDR_W'(cmd_x);
                                fb_wdata_reg <= color_reg;
                                fb_we_reg    <= 1'b1;
                                state_reg    <= S_WRITE;
                            end
                        end
                        default: begin
                            err_op_reg <= 1'b1;
                        end
                    endcase
                end
                S_WRITE: begin
                    if (fb_ready) begin
                        if (x_reg == x_last_reg) begin
                            if (y_reg == y_last_reg) begin
                                fb_we_reg <= 1'b0;
                                state_reg <= S_IDLE;
                            end else begin
                                x_reg        <= x_start_reg;
                                y_reg        <= y_reg + 1'b1;
                                row_base_reg <= next_row_base;
                                fb_addr_reg  <= next_row_base + ADDR_W'(x_start_reg);
                            end
                        end else begin
                            x_reg       <= x_reg + 1'b1;
                            fb_addr_reg <= fb_addr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    fb_we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign fb_we    = fb_we_reg;
    assign fb_addr  = fb_addr_reg;
    assign fb_wdata = fb_wdata_reg;
    assign err_ovf  = err_ovf_reg;
    assign err_op   = err_op_reg;
    assign busy     = !fifo_empty || (state_reg != S_IDLE);

endmodule

// File: tb/tb_lcd_cmd_receiver.sv
// Self-checking bench for lcd_cmd_receiver: a command-level model predicts the
// ordered list of framebuffer writes, a compare process checks every cycle
// fb_we is high, and directed scenarios pin key addresses and flags.
module tb_lcd_cmd_receiver;

    localparam int SYNC = 2;
    localparam int H    = 800;
    localparam int V    = 480;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        LCD_CMD_SIG = 1'b0;
    logic [31:0] LCD_CMD = '0;
    logic        fb_ready = 1'b0;
    logic        clr_err = 1'b0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [15:0] fb_wdata;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        err_ovf;
    logic        err_op;

    lcd_cmd_receiver #(
        .H_RES       (H),
        .V_RES       (V),
        .ADDR_W      (19),
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (SYNC)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .LCD_CMD_SIG (LCD_CMD_SIG),
        .LCD_CMD     (LCD_CMD),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .err_ovf     (err_ovf),
        .err_op      (err_op),
        .clr_err     (clr_err)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Model state
    int exp_addr_q[$];
    int exp_data_q[$];
    int acc_addr[$];
    int acc_data[$];
    int m_color = 0;
    int m_x0 = 0;
    int m_y0 = 0;
    bit m_err_op = 0;
    int ready_mode = 2;   // 0: always ready, 1: alternate, 2: never ready

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cmd_xy(input logic [3:0] op, input int x, input int y);
        return {op, 6'b0, x[10:0], y[10:0]};
    endfunction

    function automatic logic [31:0] cmd_color(input int c);
        return {4'h1, 12'h0, c[15:0]};
    endfunction

    // Command-level model: appends the writes each command must produce
    function automatic void model(input logic [31:0] w);
        int op;
        int x;
        int y;
        op = int'(w[31:28]);
        x  = int'(w[21:11]);
        y  = int'(w[10:0]);
        case (op)
            0: ;
            1: m_color = int'(w[15:0]);
            2: begin m_x0 = x; m_y0 = y; end
            3: begin
                for (int r = 0; r < y; r++)
                    for (int c = 0; c < x; c++)
                        if (m_x0 + c < H && m_y0 + r < V) begin
                            exp_addr_q.push_back((m_y0 + r) * H + m_x0 + c);
                            exp_data_q.push_back(m_color);
                        end
            end
            4: if (x < H && y < V) begin
                exp_addr_q.push_back(y * H + x);
                exp_data_q.push_back(m_color);
            end
            default: m_err_op = 1;
        endcase
    endfunction

    // fb_ready driver, changes just after the active edge
    always @(posedge HCLK) begin
        #1;
        case (ready_mode)
            0:       fb_ready = 1'b1;
            1:       fb_ready = ~fb_ready;
            default: fb_ready = 1'b0;
        endcase
    end

    // Compare every cycle a write is presented; log accepted writes
    always @(negedge HCLK) begin
        if (HRESETn && fb_we) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", fb_addr, fb_wdata);
            end else begin
                check("wr_addr", fb_addr, exp_addr_q[0]);
                check("wr_data", fb_wdata, exp_data_q[0]);
                if (fb_ready) begin
                    acc_addr.push_back(int'(fb_addr));
                    acc_data.push_back(int'(fb_wdata));
                    void'(exp_addr_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
            end
        end
    end

    // Called aligned to posedge+1; toggles the strobe and waits out the spacing
    task automatic send(input logic [31:0] w, input bit dropped = 1'b0);
        if (!dropped) model(w);
        LCD_CMD = w;
        LCD_CMD_SIG = ~LCD_CMD_SIG;
        repeat (SYNC + 2) @(posedge HCLK);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        check("idle_timeout", (n < 5000) ? 1 : 0, 1);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge HCLK);
        #1;
        clr_err = 1'b0;
        m_err_op = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lit_addr [6];
        lit_addr = '{0, 1, 2, 800, 801, 802};

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_wdata", fb_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_op", err_op, 0);
        HRESETn = 1'b1;
        ready_mode = 0;
        fb_ready = 1'b1;
        @(posedge HCLK);
        #1;

        // Single pixel with first-write latency
        send(cmd_color(16'hF800));
        wait_idle();
        acc_addr.delete(); acc_data.delete();
        model(cmd_xy(4'h4, 10, 2));
        LCD_CMD = cmd_xy(4'h4, 10, 2);
        LCD_CMD_SIG = ~LCD_CMD_SIG;
        repeat (SYNC + 2) @(posedge HCLK);
        @(negedge HCLK);
        check("lat_we_early", fb_we, 0);
        @(posedge HCLK);
        @(negedge HCLK);
        check("lat_we_on", fb_we, 1);
        @(posedge HCLK);
        #1;
        wait_idle();
        check("px_count", acc_addr.size(), 1);
        if (acc_addr.size() >= 1) begin
            check("px_addr", acc_addr[0], 1610);
            check("px_data", acc_data[0], 16'hF800);
        end
        check("px_err_ovf", err_ovf, 0);
        check("px_err_op", err_op, 0);

        // Fill clipped at bottom-right corner
        acc_addr.delete(); acc_data.delete();
        send(cmd_xy(4'h2, 798, 479));
        send(cmd_xy(4'h3, 4, 3));
        wait_idle();
        check("clip_count", acc_addr.size(), 2);
        if (acc_addr.size() >= 2) begin
            check("clip_addr0", acc_addr[0], 383998);
            check("clip_addr1", acc_addr[1], 383999);
        end

        // 3x2 fill with stalling framebuffer
        acc_addr.delete(); acc_data.delete();
        ready_mode = 1;
        send(cmd_xy(4'h2, 0, 0));
        send(cmd_xy(4'h3, 3, 2));
        wait_idle();
        ready_mode = 0;
        check("stall_count", acc_addr.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < acc_addr.size()) check("stall_addr", acc_addr[i], lit_addr[i]);

        // Overflow: 9 commands while the writer is stalled
        acc_addr.delete(); acc_data.delete();
        ready_mode = 2;
        fb_ready = 1'b0;
        send(cmd_xy(4'h3, 2, 1));
        for (int i = 0; i < 9; i++)
            send(cmd_xy(4'h4, i, 5), (i == 8));
        check("ovf_level", fifo_level, 8);
        check("ovf_flag", err_ovf, 1);
        check("ovf_busy", busy, 1);
        pulse_clr();
        check("ovf_cleared", err_ovf, 0);
        ready_mode = 0;
        wait_idle();
        check("ovf_drain_count", acc_addr.size(), 10);
        if (acc_addr.size() >= 10) check("ovf_last_addr", acc_addr[9], 4007);

        // Undefined opcode then NOP
        acc_addr.delete(); acc_data.delete();
        send(32'h7000_0000);
        wait_idle();
        check("badop_flag", err_op, m_err_op);
        check("badop_flag_lit", err_op, 1);
        check("badop_nowrite", acc_addr.size(), 0);
        send(32'h0000_0000);
        wait_idle();
        check("nop_busy", busy, 0);
        check("nop_err_op_kept", err_op, 1);
        pulse_clr();
        check("badop_cleared", err_op, 0);

        // Reset during a 100-pixel fill
        send(cmd_color(16'h1234));
        send(cmd_xy(4'h2, 0, 10));
        send(cmd_xy(4'h3, 100, 1));
        repeat (20) @(posedge HCLK);
        check("fill_active", fb_we, 1);
        #3;
        HRESETn = 1'b0;
        LCD_CMD_SIG = 1'b0;
        #1;
        check("rst_mid_we", fb_we, 0);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_busy", busy, 0);
        exp_addr_q.delete(); exp_data_q.delete();
        m_color = 0; m_x0 = 0; m_y0 = 0; m_err_op = 0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        acc_addr.delete(); acc_data.delete();
        send(cmd_xy(4'h4, 3, 4));
        wait_idle();
        check("post_rst_count", acc_addr.size(), 1);
        if (acc_addr.size() >= 1) begin
            check("post_rst_addr", acc_addr[0], 3203);
            check("post_rst_data", acc_data[0], 0);
        end

        check("exp_queue_empty", exp_addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
